// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one 32-bit word per clock,
// Start/Done handshake, 44-word schedule exposed flat.
module aes_key_expander #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Start,
  input  logic [32*NK-1:0]          Cipherkey,
  output logic                      Busy,
  output logic                      Done,
  output logic [0:32*NK*(NR+1)-1]   KeySchedule
);

  localparam int NW = NK * (NR + 1);
  localparam logic [5:0] LAST = 6'(NW - 1);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] w [NW];
  logic [5:0]  idx;
  logic [7:0]  rcon;
  logic        load;
  logic [31:0] prev;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;

  assign load = Start && (state == IDLE || state == DONE);
  assign Busy = (state == EXPAND);
  assign Done = (state == DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = EXPAND;
      EXPAND:  if (idx == LAST) state_nx = DONE;
      DONE:    if (Start) state_nx = EXPAND;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    prev = w[idx - 6'd1];
    rot  = {prev[23:0], prev[31:24]};
    sub  = {sbox(rot[31:24]), sbox(rot[23:16]),
            sbox(rot[15:8]),  sbox(rot[7:0])};
    temp = (idx[1:0] == 2'b00) ? (sub ^ {rcon, 24'h0}) : prev;
  end

  // w[4..] are left stale on load; Done qualifies the schedule.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NW; i++) w[i] <= '0;
      idx  <= '0;
      rcon <= 8'h01;
    end else if (load) begin
      for (int i = 0; i < NK; i++)
        w[i] <= Cipherkey[32*(NK-1-i) +: 32];
      idx  <= 6'(NK);
      rcon <= 8'h01;
    end else if (state == EXPAND) begin
      w[idx] <= w[idx - 6'd4] ^ temp;
      idx    <= idx + 6'd1;
      if (idx[1:0] == 2'b00)
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  always_comb begin
    KeySchedule = '0;
    for (int i = 0; i < NW; i++)
      KeySchedule[32*i +: 32] = w[i];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197
// A.1 and C.1 key schedules.
module tb_aes_key_expander;

  logic          Clk;
  logic          Reset_n;
  logic          Start;
  logic [127:0]  Cipherkey;
  logic          Busy;
  logic          Done;
  logic [0:1407] KeySchedule;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_C  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expander #(.NK(4), .NR(10)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Cipherkey  (Cipherkey),
    .Busy       (Busy),
    .Done       (Done),
    .KeySchedule(KeySchedule)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return KeySchedule[128*r +: 128];
  endfunction

  // Returns at the negedge following the sampling edge.
  task automatic pulse_start(input logic [127:0] key);
    @(negedge Clk);
    Cipherkey = key;
    Start     = 1'b1;
    @(negedge Clk);
    Start     = 1'b0;
  endtask

  task automatic run_busy(output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset_n   = 1'b1;
    Start     = 1'b0;
    Cipherkey = '0;
    #3 Reset_n = 1'b0;
    #1;
    check("rst_busy", 128'(Busy), 128'd0);
    check("rst_done", 128'(Done), 128'd0);
    check("rst_ks_zero", 128'(KeySchedule === '0), 128'd1);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("idle_busy", 128'(Busy), 128'd0);

    // A.1 from IDLE
    pulse_start(KEY_A);
    run_busy(n);
    check("a1_busy_cycles", 128'(n), 128'd40);
    check("a1_done", 128'(Done), 128'd1);
    check("a1_w4", 128'(KeySchedule[128 +: 32]), 128'ha0fafe17);
    check("a1_w5", 128'(KeySchedule[160 +: 32]), 128'h88542cb1);
    check("a1_rk1", rk(1), RK1_A);
    check("a1_rk10", rk(10), RK10_A);
    check("a1_rk0", rk(0), KEY_A);

    // restart from DONE with C.1 key
    pulse_start(KEY_C);
    check("rs_done_drop", 128'(Done), 128'd0);
    check("rs_busy", 128'(Busy), 128'd1);
    run_busy(n);
    check("rs_busy_cycles", 128'(n), 128'd40);
    check("rs_done", 128'(Done), 128'd1);
    check("c1_rk0", rk(0), KEY_C);
    check("c1_rk1", rk(1), RK1_C);
    check("c1_rk10", rk(10), RK10_C);

    // Start held high, key changed mid-expansion
    @(negedge Clk);
    Cipherkey = KEY_A;
    Start     = 1'b1;
    @(negedge Clk);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) Cipherkey = KEY_C;
      @(negedge Clk);
    end
    check("hold_busy_cycles", 128'(n), 128'd40);
    check("hold_done", 128'(Done), 128'd1);
    check("hold_rk10", rk(10), RK10_A);
    @(negedge Clk);
    check("hold_done_pulse", 128'(Done), 128'd0);
    check("hold_rebusy", 128'(Busy), 128'd1);
    Start = 1'b0;
    run_busy(n);
    check("hold2_busy_cycles", 128'(n), 128'd40);
    check("hold2_rk10", rk(10), RK10_C);

    // reset pulse in the middle of an expansion
    pulse_start(KEY_A);
    repeat (19) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(Busy), 128'd0);
    check("mid_rst_done", 128'(Done), 128'd0);
    check("mid_rst_rk0", rk(0), 128'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
    end
    check("mid_rst_stays_idle", 128'(seen), 128'd0);
    pulse_start(KEY_A);
    run_busy(n);
    check("post_rst_cycles", 128'(n), 128'd40);
    check("post_rst_done", 128'(Done), 128'd1);
    check("post_rst_rk10", rk(10), RK10_A);
    check("post_rst_rk1", rk(1), RK1_A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
